corelet_ctrl: RTL and testbench

//  Sequencer for one corelet pass: kernel load -> pipeline gap -> execution -> psum writeback.

---
 rtl/corelet_ctrl.sv | 164 ++++++++++++++++
 tb/tb_corelet_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: sequences one corelet pass (kernel load, pipeline gap, execute, psum writeback).
// Latency: xmem read issued in cycle t -> inst_w at t+1; OFIFO pop in cycle t -> pmem write at t+1.
// Backpressure: l0_full stalls xmem issue (rd_cnt holds); OFIFO pops only while ofifo_valid is high.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 pulse to begin a pass; accepted only in IDLE
//   w_base/act_base       xmem base addresses for weights / activations (latched on start)
//   out_base              pmem base address for outputs (latched on start)
//   num_act               activation vectors to stream, 0 allowed (latched on start)
//   l0_full, ofifo_valid  corelet flow-control status
//   xmem_*                activation SRAM read port (active-low enables)
//   inst_w                corelet instruction: 01 kernel load, 10 execute, 00 idle
//   ofifo_rd              OFIFO pop
//   pmem_*                psum SRAM write port (active-low enables)
//   busy, done            pass status
module corelet_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int gap     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] act_base,
  input  logic [addr_bw-1:0] out_base,
  input  logic [addr_bw-1:0] num_act,
  input  logic               l0_full,
  input  logic               ofifo_valid,
  output logic               xmem_cen,
  output logic               xmem_wen,
  output logic [addr_bw-1:0] xmem_addr,
  output logic [1:0]         inst_w,
  output logic               ofifo_rd,
  output logic               pmem_cen,
  output logic               pmem_wen,
  output logic [addr_bw-1:0] pmem_addr,
  output logic               busy,
  output logic               done
);

  // The gap must cover the array fill depth; a too-small setting is raised to row+col.
  localparam int GAP_CYC = (gap < row + col) ? (row + col) : gap;
  localparam int GAP_W   = $clog2(GAP_CYC + 1);

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  typedef enum logic [2:0] {
    IDLE, W_LOAD, W_GAP, EXEC, WAIT_OUT, DONE_ST
  } state_t;

  state_t state, state_nxt;

  logic [addr_bw-1:0] w_base_q, act_base_q, out_base_q, num_act_q;
  logic [addr_bw-1:0] rd_cnt, wr_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               issue;
  logic               pmem_wr_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = W_LOAD;
      W_LOAD:   if (issue && rd_cnt == addr_bw'(col - 1)) state_nxt = W_GAP;
      W_GAP:    if (gap_cnt == GAP_W'(GAP_CYC - 1))
                  state_nxt = (num_act_q == '0) ? WAIT_OUT : EXEC;
      EXEC:     if (issue && rd_cnt == num_act_q - 1'b1) state_nxt = WAIT_OUT;
      // wr_cnt advances in the same cycle the final pmem write is presented,
      // so reaching num_act here means that write is already on the port.
      WAIT_OUT: if (wr_cnt == num_act_q) state_nxt = DONE_ST;
      DONE_ST:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output / strobe logic
  always_comb begin
    issue     = 1'b0;
    xmem_cen  = 1'b1;
    xmem_addr = '0;
    ofifo_rd  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      W_LOAD: begin
        busy      = 1'b1;
        issue     = !l0_full;
        xmem_cen  = l0_full;
        // Address stays on the current count while stalled.
        xmem_addr = w_base_q + rd_cnt;
      end
      W_GAP: busy = 1'b1;
      EXEC: begin
        busy      = 1'b1;
        issue     = !l0_full;
        xmem_cen  = l0_full;
        xmem_addr = act_base_q + rd_cnt;
        ofifo_rd  = ofifo_valid && (wr_cnt < num_act_q);
      end
      WAIT_OUT: begin
        busy     = 1'b1;
        ofifo_rd = ofifo_valid && (wr_cnt < num_act_q);
      end
      DONE_ST: done = 1'b1;
      default: ;
    endcase
  end

  assign xmem_wen = 1'b1;
  assign pmem_cen = !pmem_wr_q;
  assign pmem_wen = !pmem_wr_q;

  // Counters, latched parameters and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      w_base_q   <= '0;
      act_base_q <= '0;
      out_base_q <= '0;
      num_act_q  <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      gap_cnt    <= '0;
      inst_w     <= INST_IDLE;
      pmem_wr_q  <= 1'b0;
      pmem_addr  <= '0;
    end else begin
      if (state == IDLE && start) begin
        w_base_q   <= w_base;
        act_base_q <= act_base;
        out_base_q <= out_base;
        num_act_q  <= num_act;
      end

      // rd_cnt restarts at each phase change so W_LOAD and EXEC both count from 0.
      if (state != state_nxt) rd_cnt <= '0;
      else if (issue)         rd_cnt <= rd_cnt + 1'b1;

      if (state == W_GAP) gap_cnt <= gap_cnt + 1'b1;
      else                gap_cnt <= '0;

      if (state == IDLE)  wr_cnt <= '0;
      else if (ofifo_rd)  wr_cnt <= wr_cnt + 1'b1;

      // inst_w lines up with the 1-cycle xmem read data.
      if (issue) inst_w <= (state == W_LOAD) ? INST_LOAD : INST_EXEC;
      else       inst_w <= INST_IDLE;

      pmem_wr_q <= ofifo_rd;
      pmem_addr <= ofifo_rd ? (out_base_q + wr_cnt) : '0;
    end
  end

endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: directed scoreboard bench for corelet_ctrl.
// Latency: checks inst_w and pmem writes one cycle after their causes.
// Backpressure: drives l0_full stalls and dense/sparse ofifo_valid patterns.
module tb_corelet_ctrl;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          reset, start, l0_full, ofifo_valid;
  logic [AW-1:0] w_base, act_base, out_base, num_act;
  logic          xmem_cen, xmem_wen, ofifo_rd, pmem_cen, pmem_wen, busy, done;
  logic [AW-1:0] xmem_addr, pmem_addr;
  logic [1:0]    inst_w;

  corelet_ctrl #(.row(8), .col(8), .addr_bw(AW), .gap(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .w_base(w_base), .act_base(act_base), .out_base(out_base), .num_act(num_act),
    .l0_full(l0_full), .ofifo_valid(ofifo_valid),
    .xmem_cen(xmem_cen), .xmem_wen(xmem_wen), .xmem_addr(xmem_addr),
    .inst_w(inst_w), .ofifo_rd(ofifo_rd),
    .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_addr(pmem_addr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [1:0] kind; } rd_t;
  rd_t           xq[$];
  logic [AW-1:0] pq[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int w_reads, a_reads, last_w_cyc, first_a_cyc, last_a_cyc, last_pmem_cyc, done_cyc;
  int vmode = 0;            // 0 off, 1 always valid, 2 sparse pulses
  int stall_arm = 0, stall_left = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  // Monitor / scoreboard consumer
  initial begin : monitor
    logic [1:0]    exp_inst;
    logic          pend;
    logic [AW-1:0] pend_addr;
    rd_t           e;
    exp_inst = 2'b00; pend = 1'b0; pend_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      check("inst_w", inst_w, exp_inst);
      check("pmem_cen", pmem_cen, !pend);
      check("pmem_wen", pmem_wen, !pend);
      check("xmem_wen", xmem_wen, 1'b1);
      if (pend) begin
        check("pmem_addr", pmem_addr, pend_addr);
        last_pmem_cyc = cyc;
      end
      exp_inst = 2'b00;
      pend     = 1'b0;
      if (xmem_cen == 1'b0) begin
        check("read_expected", xq.size() != 0, 1'b1);
        if (xq.size() != 0) begin
          e = xq.pop_front();
          check("xmem_addr", xmem_addr, e.addr);
          exp_inst = e.kind;
          if (e.kind == 2'b01) begin
            w_reads++;
            last_w_cyc = cyc;
          end else begin
            a_reads++;
            if (a_reads == 1) first_a_cyc = cyc;
            last_a_cyc = cyc;
          end
        end
      end
      if (l0_full) begin
        check("stall_cen", xmem_cen, 1'b1);
        if (a_reads > 0 && xq.size() != 0) check("stall_addr", xmem_addr, xq[0].addr);
      end
      if (ofifo_rd) begin
        check("pop_valid", ofifo_valid, 1'b1);
        check("pop_after_exec_start", a_reads > 0, 1'b1);
        check("pop_expected", pq.size() != 0, 1'b1);
        if (pq.size() != 0) begin
          pend      = 1'b1;
          pend_addr = pq.pop_front();
        end
      end
      if (done) done_cyc = cyc;
      if (reset) begin
        exp_inst = 2'b00;
        pend     = 1'b0;
      end
    end
  end

  // Flow-control input drivers
  initial begin : fc_drv
    ofifo_valid = 1'b0;
    l0_full     = 1'b0;
    forever begin
      tick();
      case (vmode)
        1:       ofifo_valid = 1'b1;
        2:       ofifo_valid = (cyc % 5 == 0);
        default: ofifo_valid = 1'b0;
      endcase
      if (stall_arm != 0 && a_reads == 2) begin
        stall_arm  = 0;
        stall_left = 3;
      end
      l0_full = (stall_left > 0);
      if (stall_left > 0) stall_left--;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_xmem_cen"},  xmem_cen,  1'b1);
    check({tag, "_xmem_addr"}, xmem_addr, '0);
    check({tag, "_inst_w"},    inst_w,    2'b00);
    check({tag, "_ofifo_rd"},  ofifo_rd,  1'b0);
    check({tag, "_pmem_cen"},  pmem_cen,  1'b1);
    check({tag, "_pmem_wen"},  pmem_wen,  1'b1);
    check({tag, "_pmem_addr"}, pmem_addr, '0);
    check({tag, "_busy"},      busy,      1'b0);
    check({tag, "_done"},      done,      1'b0);
  endtask

  // Called at posedge+1 in IDLE; returns at negedge+1 of the first busy cycle.
  task automatic start_pass(input logic [AW-1:0] w, a, o, n);
    for (int i = 0; i < 8; i++) xq.push_back('{addr: AW'(w + i), kind: 2'b01});
    for (int i = 0; i < int'(n); i++) begin
      xq.push_back('{addr: AW'(a + i), kind: 2'b10});
      pq.push_back(AW'(o + i));
    end
    w_reads = 0; a_reads = 0; last_w_cyc = 0; first_a_cyc = 0; last_a_cyc = 0;
    last_pmem_cyc = 0; done_cyc = 0;
    w_base = w; act_base = a; out_base = o; num_act = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble the inputs: the pass must run on the latched copies.
    w_base = AW'($urandom); act_base = AW'($urandom);
    out_base = AW'($urandom); num_act = AW'($urandom);
    sample();
    check("busy_after_start", busy, 1'b1);
  endtask

  // Returns at negedge+1 of the cycle after done.
  task automatic wait_done(input string tag, input int n, input bit start_in_done);
    int k;
    k = 0;
    while (!done && k < 3000) begin
      sample();
      k++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_xq_empty"}, xq.size(), 0);
    check({tag, "_pq_empty"}, pq.size(), 0);
    check({tag, "_w_reads"}, w_reads, 8);
    check({tag, "_a_reads"}, a_reads, n);
    if (n > 0) begin
      check({tag, "_gap"}, first_a_cyc - last_w_cyc, 17);
      check({tag, "_done_cyc"}, done_cyc,
            ((last_pmem_cyc > last_a_cyc + 1) ? last_pmem_cyc : last_a_cyc + 1) + 1);
    end else begin
      check({tag, "_done_cyc"}, done_cyc, last_w_cyc + 18);
    end
    if (start_in_done) start = 1'b1;
    tick();
    start = 1'b0;
    sample();
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_busy_idle"}, busy, 1'b0);
    sample();
    check({tag, "_busy_idle2"}, busy, 1'b0);
  endtask

  initial begin : main
    int k;
    reset = 1'b1; start = 1'b0;
    w_base = '0; act_base = '0; out_base = '0; num_act = '0;
    repeat (3) tick();
    sample();
    check_reset_outputs("reset");
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // 1: basic pass, dense OFIFO, start pulsed in DONE
    vmode = 1;
    start_pass(11'd0, 11'd8, 11'd0, 11'd4);
    wait_done("basic", 4, 1'b1);
    tick();

    // 2: 3-cycle L0 stall mid-EXEC
    stall_arm = 1;
    start_pass(11'd16, 11'd40, 11'd20, 11'd4);
    wait_done("stall", 4, 1'b0);
    tick();

    // 3: sparse OFIFO pulses, out_base=100
    vmode = 2;
    start_pass(11'd0, 11'd8, 11'd100, 11'd4);
    wait_done("sparse", 4, 1'b0);
    tick();

    // 4: num_act=0
    vmode = 1;
    start_pass(11'd5, 11'd8, 11'd0, 11'd0);
    wait_done("noact", 0, 1'b0);
    tick();

    // 5a: start during EXEC is ignored
    start_pass(11'd0, 11'd200, 11'd50, 11'd6);
    k = 0;
    while (a_reads < 1 && k < 200) begin sample(); k++; end
    check("exec_reached", a_reads >= 1, 1'b1);
    tick();
    w_base = 11'd700; act_base = 11'd900; out_base = 11'd300; num_act = 11'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_start", 6, 1'b0);
    tick();

    // 5b: reset mid-W_LOAD aborts the pass
    vmode = 0;
    start_pass(11'd64, 11'd80, 11'd10, 11'd4);
    k = 0;
    while (w_reads < 3 && k < 50) begin sample(); k++; end
    check("wload_reached", w_reads >= 3, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    xq.delete();
    pq.delete();
    sample();
    check_reset_outputs("midreset");
    repeat (30) sample();
    check("post_reset_busy", busy, 1'b0);
    check("post_reset_reads", w_reads, 4);
    tick();

    // 6: activation address wrap
    vmode = 1;
    start_pass(11'd0, 11'd2046, 11'd2046, 11'd4);
    wait_done("wrap", 4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
    $fatal(1);
  end

endmodule
